lpddr2_avm_arbiter: RTL and testbench
=====================================

# lpddr2_avm_arbiter

Two-requester Avalon-MM arbiter that shares the single LPDDR2 MPFE port between the instruction-side and data-side bus bridges. It sits in the `avm_clk` domain between the two bridges and the memory controller port. It registers the granted command, alternates priority round-robin, and tracks outstanding reads so that `readdatavalid` is routed back to the correct requester. No grant is issued until calibration is reported ready.

## Interface
- `ADDR_W`, 27: word address width.
- `DATA_W`, 32: data width; byteenable width is `DATA_W/8`.
- `MAX_RD`, 4: maximum outstanding reads (tag FIFO depth, ≥1).

- `avm_clk` in 1: single clock for the whole block.
- `avm_rst` in 1: asynchronous, active-high reset.
- `cal_ready` in 1: memory calibrated and MPFE out of reset, already synchronous to `avm_clk`.
- `rN_address` in ADDR_W (N=0,1): requester address.
- `rN_read` in 1: requester read.
- `rN_write` in 1: requester write.
- `rN_writedata` in DATA_W: requester write data.
- `rN_byteenable` in DATA_W/8: requester byte enables.
- `rN_waitrequest` out 1: stall to requester.
- `rN_readdata` out DATA_W: read data to requester.
- `rN_readdatavalid` out 1: read data valid to requester.
- `m_address` out ADDR_W: MPFE address.
- `m_read` out 1: MPFE read.
- `m_write` out 1: MPFE write.
- `m_writedata` out DATA_W: MPFE write data.
- `m_byteenable` out DATA_W/8: MPFE byte enables.
- `m_waitrequest` in 1: MPFE stall.
- `m_readdata` in DATA_W: MPFE read data.
- `m_readdatavalid` in 1: MPFE read data valid.
- `err_orphan` out 1: sticky flag; set when `readdatavalid` arrives while no read is outstanding.

## Operation
- Requester N is requesting when `rN_read|rN_write`. If both are asserted, the command is treated as a write.
- Eligibility:
  - A read is eligible only if `tag_count < MAX_RD`.
  - Writes ignore the tag count.
  - No request is eligible while `cal_ready=0`.
- FSM states are IDLE and ISSUE.
  - **IDLE:** if at least one requester is eligible, grant per priority. The `prio` bit names the preferred requester; if only one requester is eligible, it wins.
    - Capture address, data, byteenable and kind into the command register.
    - Drive the winner's `rN_waitrequest` low for that cycle.
    - Push the winner's ID to the tag FIFO if the command is a read.
    - Set `prio` to the loser's ID.
    - Go to ISSUE.
  - **ISSUE:** drive `m_*` from the command register and hold it stable while `m_waitrequest=1`. The cycle `m_waitrequest=0` accepts the command: clear `m_read`/`m_write` and go to IDLE.
- `rN_waitrequest` is 1 in every cycle except the capture cycle of requester N.
- Read return:
  - On `m_readdatavalid`, route `m_readdata` to the requester at the FIFO head and pulse its `rN_readdatavalid`.
  - Pop the head.
  - `rN_readdata` is the combinational copy of `m_readdata` for both requesters.
- Boundary rules:
  - **`cal_ready` drops during ISSUE:** the pending command still completes; no new grants are made.
  - **Push and pop in the same cycle:** both take effect and the count is unchanged. Eligibility uses the count before that cycle, so a full FIFO blocks a read even if a pop occurs in the same cycle.
  - **`m_readdatavalid` with the FIFO empty:** data is dropped, no `rN_readdatavalid` is raised, and `err_orphan` is set. Only reset clears `err_orphan`.
  - **Reset mid-operation:** the command is dropped, the FIFO is emptied, and in-flight return data after reset counts as orphan.

## Timing
- Reset values:
  - IDLE state, `prio=0`.
  - `m_read`, `m_write`, `m_address`, `m_writedata`, `m_byteenable` are 0.
  - `rN_waitrequest=1`, `rN_readdatavalid=0`, `err_orphan=0`, tag FIFO empty.
- Grant-to-issue latency: the command appears on `m_*` 1 cycle after the capture cycle.
- Peak throughput: one command per 2 cycles when `m_waitrequest=0`.
- Read return: `rN_readdatavalid` is combinational from `m_readdatavalid` (0 added cycles).
- Return ordering follows MPFE in-order return.

## Structure
- Package `lpddr2_arb_pkg` holds:
  - the state enum (IDLE, ISSUE);
  - the `req_id_t` 1-bit requester ID type;
  - the command-kind constants CMD_RD and CMD_WR.
- Sub-module `lpddr2_tag_fifo`: synchronous FIFO with `MAX_RD` entries of `req_id_t`. It provides push, pop, head, count (width `$clog2(MAX_RD+1)`), full and empty. Pop on empty is ignored and reported as orphan by the parent.

## Test plan
- **Calibration gate:** `cal_ready=0`, r0 reads address 0x10 → `r0_waitrequest` stays 1 and `m_read` stays 0. Raise `cal_ready` → capture on the next edge and `m_read` with `m_address=0x10` one cycle later.
- **Round-robin:** r0 and r1 each issue continuous writes, `m_waitrequest=0` → grants alternate r0, r1, r0, r1 (after reset, r0 first) and 4 commands complete in 8 cycles.
- **Backpressure:** `m_waitrequest` held high 5 cycles on a write of data 0xDEADBEEF → `m_*` stable all 5 cycles, command released on the cycle `m_waitrequest=0`.
- **Read tag routing:** reads issued in order r1, r0, r1, r0 (`MAX_RD=4`); return data A, B, C, D → r1 gets A and C, r0 gets B and D. A 5th read is held until the first return.
- **Orphan and reset:** pulse `m_readdatavalid` with no reads outstanding → no `rN_readdatavalid`, `err_orphan=1`. Assert `avm_rst` during ISSUE → all outputs return to their reset values asynchronously and `err_orphan=0`.

Source files
------------

// File: rtl/lpddr2_arb_pkg.sv
// Shared types for the LPDDR2 Avalon-MM arbiter.
// Holds the FSM states, the requester ID type and the command-kind encodings.
package lpddr2_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   typedef logic req_id_t;

   localparam logic CMD_RD = 1'b0;
   localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/lpddr2_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each outstanding MPFE read, in issue order.
// Pop on empty and push on full are ignored; the parent flags orphan returns itself.
module lpddr2_tag_fifo
   import lpddr2_arb_pkg::*;
#(
   parameter  int MAX_RD = 4,
   localparam int CNT_W  = $clog2(MAX_RD + 1),
   localparam int PTR_W  = (MAX_RD > 1) ? $clog2(MAX_RD) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  req_id_t          push_id_i,
   input  logic             pop_i,
   output req_id_t          head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o,
   output logic             empty_o
);

   req_id_t          mem_q [MAX_RD];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_RD - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CNT_W'(MAX_RD));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // NOTE: the tag storage is not reset; pointers and count alone decide which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_id_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/lpddr2_avm_arbiter.sv
// Two-requester Avalon-MM arbiter sharing one LPDDR2 MPFE port between the instruction and data bridges.
// Round-robin grant, one registered command in flight, read tags route readdatavalid back in return order.
module lpddr2_avm_arbiter
   import lpddr2_arb_pkg::*;
#(
   parameter int ADDR_W = 27,
   parameter int DATA_W = 32,
   parameter int MAX_RD = 4
) (
   input  logic                avm_clk,
   input  logic                avm_rst,
   input  logic                cal_ready,

   input  logic [ADDR_W-1:0]   r0_address,
   input  logic                r0_read,
   input  logic                r0_write,
   input  logic [DATA_W-1:0]   r0_writedata,
   input  logic [DATA_W/8-1:0] r0_byteenable,
   output logic                r0_waitrequest,
   output logic [DATA_W-1:0]   r0_readdata,
   output logic                r0_readdatavalid,

   input  logic [ADDR_W-1:0]   r1_address,
   input  logic                r1_read,
   input  logic                r1_write,
   input  logic [DATA_W-1:0]   r1_writedata,
   input  logic [DATA_W/8-1:0] r1_byteenable,
   output logic                r1_waitrequest,
   output logic [DATA_W-1:0]   r1_readdata,
   output logic                r1_readdatavalid,

   output logic [ADDR_W-1:0]   m_address,
   output logic                m_read,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic [DATA_W/8-1:0] m_byteenable,
   input  logic                m_waitrequest,
   input  logic [DATA_W-1:0]   m_readdata,
   input  logic                m_readdatavalid,

   output logic                err_orphan
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(MAX_RD + 1);

   state_e            state_q, state_d;
   req_id_t           prio_q, prio_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
   logic [BE_W-1:0]   cmd_be_q, cmd_be_d;
   logic              cmd_kind_q, cmd_kind_d;
   logic              err_orphan_q, err_orphan_d;

   logic              arb_en;
   logic              rd_room;
   logic              elig0, elig1;
   req_id_t           winner;
   logic              win_write;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic [BE_W-1:0]   win_be;
   logic              grant;

   logic              tag_push;
   req_id_t           tag_head;
   logic [CNT_W-1:0]  tag_count;
   logic              tag_full;
   logic              tag_empty;

   // Reset is folded in so a requester never sees waitrequest drop while the block is held in reset.
   assign arb_en  = cal_ready & ~avm_rst;
   assign rd_room = (tag_count < CNT_W'(MAX_RD));
   assign elig0   = arb_en & (r0_write | (r0_read & rd_room));
   assign elig1   = arb_en & (r1_write | (r1_read & rd_room));

   assign winner    = (elig0 & elig1) ? prio_q : req_id_t'(elig1);
   assign win_write = winner ? r1_write      : r0_write;
   assign win_addr  = winner ? r1_address    : r0_address;
   assign win_data  = winner ? r1_writedata  : r0_writedata;
   assign win_be    = winner ? r1_byteenable : r0_byteenable;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      prio_d     = prio_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
      cmd_be_d   = cmd_be_q;
      cmd_kind_d = cmd_kind_q;
      grant      = 1'b0;
      case (state_q)
         IDLE: begin
            if (elig0 | elig1) begin
               grant      = 1'b1;
               cmd_addr_d = win_addr;
               cmd_data_d = win_data;
               cmd_be_d   = win_be;
               cmd_kind_d = win_write ? CMD_WR : CMD_RD;
               prio_d     = ~winner;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (!m_waitrequest) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tag_push     = grant & ~win_write & ~tag_full;
   assign err_orphan_d = err_orphan_q | (m_readdatavalid & tag_empty);

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_data_q   <= '0;
         cmd_be_q     <= '0;
         cmd_kind_q   <= CMD_RD;
         err_orphan_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_data_q   <= cmd_data_d;
         cmd_be_q     <= cmd_be_d;
         cmd_kind_q   <= cmd_kind_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   lpddr2_tag_fifo #(
      .MAX_RD (MAX_RD)
   ) u_tag_fifo (
      .clk_i     (avm_clk),
      .rst_i     (avm_rst),
      .push_i    (tag_push),
      .push_id_i (winner),
      .pop_i     (m_readdatavalid),
      .head_o    (tag_head),
      .count_o   (tag_count),
      .full_o    (tag_full),
      .empty_o   (tag_empty)
   );

   assign m_address    = cmd_addr_q;
   assign m_writedata  = cmd_data_q;
   assign m_byteenable = cmd_be_q;
   assign m_read       = (state_q == ISSUE) & (cmd_kind_q == CMD_RD);
   assign m_write      = (state_q == ISSUE) & (cmd_kind_q == CMD_WR);

   assign r0_waitrequest = ~(grant & (winner == 1'b0));
   assign r1_waitrequest = ~(grant & (winner == 1'b1));

   assign r0_readdata      = m_readdata;
   assign r1_readdata      = m_readdata;
   assign r0_readdatavalid = m_readdatavalid & ~tag_empty & (tag_head == 1'b0);
   assign r1_readdatavalid = m_readdatavalid & ~tag_empty & (tag_head == 1'b1);

   assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_lpddr2_avm_arbiter.sv
// Directed bench for lpddr2_avm_arbiter: calibration gate, round-robin, backpressure,
// read tag routing with a full tag FIFO, orphan returns and asynchronous reset.
module tb_lpddr2_avm_arbiter;

   localparam int ADDR_W = 27;
   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   logic              avm_clk;
   logic              avm_rst;
   logic              cal_ready;
   logic [ADDR_W-1:0] r0_address, r1_address;
   logic              r0_read, r1_read, r0_write, r1_write;
   logic [DATA_W-1:0] r0_writedata, r1_writedata;
   logic [BE_W-1:0]   r0_byteenable, r1_byteenable;
   logic              r0_waitrequest, r1_waitrequest;
   logic [DATA_W-1:0] r0_readdata, r1_readdata;
   logic              r0_readdatavalid, r1_readdatavalid;
   logic [ADDR_W-1:0] m_address;
   logic              m_read, m_write;
   logic [DATA_W-1:0] m_writedata;
   logic [BE_W-1:0]   m_byteenable;
   logic              m_waitrequest;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;
   logic              err_orphan;

   int n_checks = 0;
   int n_pass   = 0;

   lpddr2_avm_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .MAX_RD (4)
   ) dut (
      .avm_clk          (avm_clk),
      .avm_rst          (avm_rst),
      .cal_ready        (cal_ready),
      .r0_address       (r0_address),
      .r0_read          (r0_read),
      .r0_write         (r0_write),
      .r0_writedata     (r0_writedata),
      .r0_byteenable    (r0_byteenable),
      .r0_waitrequest   (r0_waitrequest),
      .r0_readdata      (r0_readdata),
      .r0_readdatavalid (r0_readdatavalid),
      .r1_address       (r1_address),
      .r1_read          (r1_read),
      .r1_write         (r1_write),
      .r1_writedata     (r1_writedata),
      .r1_byteenable    (r1_byteenable),
      .r1_waitrequest   (r1_waitrequest),
      .r1_readdata      (r1_readdata),
      .r1_readdatavalid (r1_readdatavalid),
      .m_address        (m_address),
      .m_read           (m_read),
      .m_write          (m_write),
      .m_writedata      (m_writedata),
      .m_byteenable     (m_byteenable),
      .m_waitrequest    (m_waitrequest),
      .m_readdata       (m_readdata),
      .m_readdatavalid  (m_readdatavalid),
      .err_orphan       (err_orphan)
   );

   initial avm_clk = 1'b0;
   always #5 avm_clk = ~avm_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; each read is granted this cycle and issued the next.
   task automatic issue_read(input int id, input logic [ADDR_W-1:0] addr);
      if (id == 0) begin
         r0_read    = 1'b1;
         r0_address = addr;
      end else begin
         r1_read    = 1'b1;
         r1_address = addr;
      end
      #1;
      check("rd_grant", (id == 0) ? r0_waitrequest : r1_waitrequest, 0);
      @(negedge avm_clk);
      r0_read = 1'b0;
      r1_read = 1'b0;
      #1;
      check("rd_issue_read", m_read, 1);
      check("rd_issue_addr", m_address, addr);
      @(negedge avm_clk);
   endtask

   initial begin
      int n_acc;
      int exp_id;

      avm_rst         = 1'b1;
      cal_ready       = 1'b0;
      r0_address      = '0;
      r1_address      = '0;
      r0_read         = 1'b0;
      r1_read         = 1'b0;
      r0_write        = 1'b0;
      r1_write        = 1'b0;
      r0_writedata    = '0;
      r1_writedata    = '0;
      r0_byteenable   = '0;
      r1_byteenable   = '0;
      m_waitrequest   = 1'b0;
      m_readdata      = '0;
      m_readdatavalid = 1'b0;

      // Reset values
      repeat (2) @(negedge avm_clk);
      #1;
      check("rst_m_read", m_read, 0);
      check("rst_m_write", m_write, 0);
      check("rst_m_address", m_address, 0);
      check("rst_r0_wait", r0_waitrequest, 1);
      check("rst_r1_wait", r1_waitrequest, 1);
      check("rst_rdv", {r0_readdatavalid, r1_readdatavalid}, 0);
      check("rst_orphan", err_orphan, 0);
      @(negedge avm_clk);
      avm_rst = 1'b0;

      // Calibration gate
      r0_address = 27'h10;
      r0_read    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("cal_gate_wait", r0_waitrequest, 1);
         check("cal_gate_mread", m_read, 0);
         @(negedge avm_clk);
      end
      cal_ready = 1'b1;
      #1;
      check("cal_grant_wait", r0_waitrequest, 0);
      @(negedge avm_clk);
      r0_read = 1'b0;
      #1;
      check("cal_issue_read", m_read, 1);
      check("cal_issue_addr", m_address, 27'h10);
      check("cal_issue_wait", r0_waitrequest, 1);
      @(negedge avm_clk);
      #1;
      check("cal_done_read", m_read, 0);
      m_readdata      = 32'h1234_5678;
      m_readdatavalid = 1'b1;
      #1;
      check("cal_ret_r0_rdv", r0_readdatavalid, 1);
      check("cal_ret_r0_data", r0_readdata, 32'h1234_5678);
      check("cal_ret_r1_rdv", r1_readdatavalid, 0);
      @(negedge avm_clk);
      m_readdatavalid = 1'b0;

      // Round-robin, two continuous writers, r0 first after reset
      avm_rst = 1'b1;
      @(negedge avm_clk);
      avm_rst       = 1'b0;
      r0_write      = 1'b1;
      r0_address    = 27'h100;
      r0_writedata  = 32'hA0;
      r0_byteenable = 4'hF;
      r1_write      = 1'b1;
      r1_address    = 27'h200;
      r1_writedata  = 32'hB1;
      r1_byteenable = 4'h3;
      n_acc         = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         exp_id = (i / 2) % 2;
         if (i % 2 == 0) begin
            check("rr_r0_wait", r0_waitrequest, (exp_id != 0));
            check("rr_r1_wait", r1_waitrequest, (exp_id != 1));
            check("rr_gap_write", m_write, 0);
         end else begin
            check("rr_write", m_write, 1);
            check("rr_addr", m_address, (exp_id == 1) ? 27'h200 : 27'h100);
            check("rr_data", m_writedata, (exp_id == 1) ? 32'hB1 : 32'hA0);
            if (m_write && !m_waitrequest) n_acc++;
         end
         @(negedge avm_clk);
      end
      check("rr_accepts", n_acc, 4);
      r0_write = 1'b0;
      r1_write = 1'b0;

      // Backpressure; cal_ready drops during ISSUE and the command still completes
      m_waitrequest = 1'b1;
      r1_write      = 1'b1;
      r1_address    = 27'h55;
      r1_writedata  = 32'hDEADBEEF;
      r1_byteenable = 4'b0110;
      #1;
      check("bp_grant", r1_waitrequest, 0);
      @(negedge avm_clk);
      r1_write   = 1'b0;
      cal_ready  = 1'b0;
      r0_write   = 1'b1;
      r0_address = 27'h77;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_write", m_write, 1);
         check("bp_addr", m_address, 27'h55);
         check("bp_data", m_writedata, 32'hDEADBEEF);
         check("bp_be", m_byteenable, 4'b0110);
         @(negedge avm_clk);
      end
      m_waitrequest = 1'b0;
      #1;
      check("bp_accept_write", m_write, 1);
      @(negedge avm_clk);
      #1;
      check("bp_released", m_write, 0);
      check("nocal_r0_wait", r0_waitrequest, 1);
      @(negedge avm_clk);
      #1;
      check("nocal_r0_wait2", r0_waitrequest, 1);
      check("nocal_no_cmd", m_write, 0);
      r0_write  = 1'b0;
      cal_ready = 1'b1;

      // Read tag routing with a full FIFO
      issue_read(1, 27'h301);
      issue_read(0, 27'h302);
      issue_read(1, 27'h303);
      issue_read(0, 27'h304);
      r0_read    = 1'b1;
      r0_address = 27'h305;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("full_hold_wait", r0_waitrequest, 1);
         check("full_hold_read", m_read, 0);
         @(negedge avm_clk);
      end
      m_readdatavalid = 1'b1;
      m_readdata      = 32'hAAAA_0001;
      #1;
      check("ret_a_r1_rdv", r1_readdatavalid, 1);
      check("ret_a_r1_data", r1_readdata, 32'hAAAA_0001);
      check("ret_a_r0_rdv", r0_readdatavalid, 0);
      check("ret_a_full_wait", r0_waitrequest, 1);
      @(negedge avm_clk);
      m_readdatavalid = 1'b0;
      #1;
      check("fifth_grant", r0_waitrequest, 0);
      @(negedge avm_clk);
      r0_read         = 1'b0;
      m_readdatavalid = 1'b1;
      m_readdata      = 32'hBBBB_0002;
      #1;
      check("fifth_issue_read", m_read, 1);
      check("fifth_issue_addr", m_address, 27'h305);
      check("ret_b_r0_rdv", r0_readdatavalid, 1);
      check("ret_b_r1_rdv", r1_readdatavalid, 0);
      check("ret_b_r0_data", r0_readdata, 32'hBBBB_0002);
      @(negedge avm_clk);
      m_readdata = 32'hCCCC_0003;
      #1;
      check("ret_c_r1_rdv", r1_readdatavalid, 1);
      check("ret_c_r0_rdv", r0_readdatavalid, 0);
      check("ret_c_r1_data", r1_readdata, 32'hCCCC_0003);
      @(negedge avm_clk);
      m_readdata = 32'hDDDD_0004;
      #1;
      check("ret_d_r0_rdv", r0_readdatavalid, 1);
      check("ret_d_r1_rdv", r1_readdatavalid, 0);
      @(negedge avm_clk);
      m_readdata = 32'hEEEE_0005;
      #1;
      check("ret_e_r0_rdv", r0_readdatavalid, 1);
      check("ret_e_r1_rdv", r1_readdatavalid, 0);
      @(negedge avm_clk);
      m_readdatavalid = 1'b0;
      #1;
      check("no_orphan_yet", err_orphan, 0);

      // Orphan return
      m_readdatavalid = 1'b1;
      m_readdata      = 32'h0000_0BAD;
      #1;
      check("orphan_r0_rdv", r0_readdatavalid, 0);
      check("orphan_r1_rdv", r1_readdatavalid, 0);
      @(negedge avm_clk);
      m_readdatavalid = 1'b0;
      #1;
      check("orphan_set", err_orphan, 1);
      @(negedge avm_clk);
      #1;
      check("orphan_sticky", err_orphan, 1);

      // Asynchronous reset while a write sits in ISSUE
      m_waitrequest = 1'b1;
      r0_write      = 1'b1;
      r0_address    = 27'h400;
      r0_writedata  = 32'h5A5A;
      r0_byteenable = 4'hF;
      @(negedge avm_clk);
      #1;
      check("pre_rst_write", m_write, 1);
      check("pre_rst_addr", m_address, 27'h400);
      #1;
      avm_rst = 1'b1;
      #1;
      check("arst_write", m_write, 0);
      check("arst_read", m_read, 0);
      check("arst_addr", m_address, 0);
      check("arst_data", m_writedata, 0);
      check("arst_be", m_byteenable, 0);
      check("arst_orphan", err_orphan, 0);
      check("arst_r0_wait", r0_waitrequest, 1);
      check("arst_r1_wait", r1_waitrequest, 1);
      @(negedge avm_clk);
      r0_write      = 1'b0;
      m_waitrequest = 1'b0;
      avm_rst       = 1'b0;
      @(negedge avm_clk);
      #1;
      check("post_rst_idle", m_write, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
